ext_pipe: RTL

//   Registered, handshaked extension unit for the MIPS datapath. Covers immediate

---
 rtl/ext_pipe.sv | 106 ++++++++++
 1 files changed

// File: rtl/ext_pipe.sv
// Registered, handshaked immediate/load-data extension unit with a 1-entry skid
// buffer; in_ready depends only on registered state.
module ext_pipe #(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_mode,
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        in_off,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              err;
  } ent_t;

  logic m_vld_q, m_vld_d, s_vld_q, s_vld_d;
  ent_t m_q, m_d, s_q, s_d;
  ent_t res;

  logic [IMM_W-1:0] imm;
  logic [7:0]       lane_b;
  logic [15:0]      lane_h;
  logic             acc, pop;

  assign imm    = in_data[IMM_W-1:0];
  assign lane_b = in_data[{in_off, 3'b000} +: 8];
  assign lane_h = in_off[1] ? in_data[31:16] : in_data[15:0];

  always_comb begin
    res = '0;
    case (in_mode)
      3'd0: res.data = {{(DATA_W-IMM_W){1'b0}}, imm};
      3'd1: res.data = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
      3'd2: res.data = {imm, {(DATA_W-IMM_W){1'b0}}};
      3'd3: res.data = {{(DATA_W-8){1'b0}}, lane_b};
      3'd4: res.data = {{(DATA_W-8){lane_b[7]}}, lane_b};
      3'd5, 3'd6: begin
        // Odd byte address on a half access: flag it and zero the data.
        if (in_off[0])         res.err  = 1'b1;
        else if (in_mode[0])   res.data = {{(DATA_W-16){1'b0}}, lane_h};
        else                   res.data = {{(DATA_W-16){lane_h[15]}}, lane_h};
      end
      default: res.data = in_data;
    endcase
  end

  assign in_ready  = !s_vld_q;
  assign out_valid = m_vld_q;
  assign out_data  = m_q.data;
  assign out_err   = m_q.err;
  assign acc       = in_valid & in_ready;
  assign pop       = m_vld_q & out_ready;

  always_comb begin
    m_vld_d = m_vld_q;
    s_vld_d = s_vld_q;
    m_d     = m_q;
    s_d     = s_q;
    if (flush) begin
      m_vld_d = 1'b0;
      s_vld_d = 1'b0;
    end else if (!m_vld_q) begin
      if (acc) begin
        m_vld_d = 1'b1;
        m_d     = res;
      end
    end else if (pop) begin
      if (s_vld_q) begin
        m_d     = s_q;
        s_vld_d = 1'b0;
      end else if (acc) begin
        m_d = res;
      end else begin
        m_vld_d = 1'b0;
      end
    end else if (acc) begin
      s_vld_d = 1'b1;
      s_d     = res;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_vld_q <= 1'b0;
      s_vld_q <= 1'b0;
      m_q     <= '0;
      s_q     <= '0;
    end else begin
      m_vld_q <= m_vld_d;
      s_vld_q <= s_vld_d;
      m_q     <= m_d;
      s_q     <= s_d;
    end
  end

endmodule
